// File: rtl/fcall_arbiter.sv
// Round-robin arbiter sharing one function-evaluation unit (SUM/DOUBLE/NO_ARGS) among N_REQ callers.
// Optional macro FCALL_ERR_EN: opcode 2'b11 returns data 0 with rsp_err_o set instead of decoding as SUM.
module fcall_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [2*N_REQ-1:0]   req_op_i,
    input  logic [8*N_REQ-1:0]   req_x_i,
    input  logic [8*N_REQ-1:0]   req_y_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [7:0]           rsp_data_o,
    output logic                 rsp_err_o,
    output logic [15:0]          calls_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  id_q;
    logic [1:0]      op_q;
    logic [7:0]      x_q;
    logic [7:0]      y_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [7:0]      rsp_data_q;
    logic [15:0]     calls_done_q;
`ifdef FCALL_ERR_EN
    logic            rsp_err_q;
`endif

    logic [1:0]      op_a [N_REQ];
    logic [7:0]      x_a  [N_REQ];
    logic [7:0]      y_a  [N_REQ];
    logic            win_valid_s;
    logic [IDW-1:0]  win_id_s;
    logic [7:0]      eval_data_s;

    function automatic logic [7:0] fcall_eval(input logic [1:0] op,
                                              input logic [7:0] x,
                                              input logic [7:0] y);
        logic [7:0] res;
        case (op)
            2'b00:   res = x + y;
            2'b01:   res = {4'b0000, x[2:0], 1'b0};
            2'b10:   res = 8'd1;
`ifdef FCALL_ERR_EN
            default: res = 8'd0;
`else
            default: res = x + y;
`endif
        endcase
        return res;
    endfunction

`ifdef FCALL_ERR_EN
    function automatic logic fcall_is_err(input logic [1:0] op);
        return (op == 2'b11);
    endfunction
`endif

    genvar g;
    for (g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_a[g] = req_op_i[2*g +: 2];
        assign x_a[g]  = req_x_i[8*g +: 8];
        assign y_a[g]  = req_y_i[8*g +: 8];
    end

    // Winner search: first valid requester at or above rr_ptr_q, wrapping (N_REQ is a power of two).
    always_comb begin : arb_search
        logic [IDW-1:0] cand_s;
        cand_s      = rr_ptr_q;
        win_valid_s = 1'b0;
        win_id_s    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = rr_ptr_q + IDW'(k);
            if (!win_valid_s && req_valid_i[cand_s]) begin
                win_valid_s = 1'b1;
                win_id_s    = cand_s;
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Grant is combinational so the requester sees ready in the cycle it is picked.
    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_IDLE && win_valid_s) begin
            req_ready_o[win_id_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    assign eval_data_s = fcall_eval(op_q, x_q, y_q);

    // Call sequencer: IDLE accepts, EXEC evaluates into the response registers, RESP waits for the consumer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_q         <= 2'b00;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= 8'd0;
            calls_done_q <= 16'd0;
`ifdef FCALL_ERR_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        id_q    <= win_id_s;
                        op_q    <= op_a[win_id_s];
                        x_q     <= x_a[win_id_s];
                        y_q     <= y_a[win_id_s];
                        state_q <= ST_EXEC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rsp_id_q    <= id_q;
                    rsp_data_q  <= eval_data_s;
`ifdef FCALL_ERR_EN
                    rsp_err_q   <= fcall_is_err(op_q);
`endif
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q  <= 1'b0;
                        rr_ptr_q     <= rsp_id_q + IDW'(1);
                        calls_done_q <= calls_done_q + 16'd1;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q      <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_data_o   = rsp_data_q;
    assign calls_done_o = calls_done_q;
`ifdef FCALL_ERR_EN
    assign rsp_err_o    = rsp_err_q;
`else
    assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fcall_arbiter.sv
// Bench for fcall_arbiter: cycle-level reference model with a response scoreboard, a vector table
// and hand-written sequences for round-robin order, back-pressure and mid-call reset.
module tb_fcall_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op;
    logic [8*N-1:0]  req_x;
    logic [8*N-1:0]  req_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [7:0]      rsp_data;
    logic            rsp_err;
    logic [15:0]     calls_done;

    always #5 clk = ~clk;

    fcall_arbiter #(.N_REQ(N), .IDW(IDW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_x_i(req_x), .req_y_i(req_y),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .calls_done_o(calls_done)
    );

    typedef struct { int id; int data; int err; } rsp_t;
    typedef struct { int id; int op; int x; int y; int exp_data; int exp_err; } vec_t;

    int checks = 0;
    int failures = 0;
    rsp_t sb[$];
    int gnt_log[$];
    int hs_log[$];
    int cyc = 0;

    // Reference model state (0 idle, 1 exec, 2 resp)
    int m_state = 0, m_ptr = 0, m_calls = 0;
    int m_rv = 0, m_id = 0, m_data = 0, m_err = 0;
    int lat_id = 0, lat_data = 0, lat_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_data(input int op, input int x, input int y);
        case (op)
            0: return (x + y) % 256;
            1: return (x * 2) % 16;
            2: return 1;
`ifdef FCALL_ERR_EN
            default: return 0;
`else
            default: return (x + y) % 256;
`endif
        endcase
    endfunction

    function automatic int ref_err(input int op);
`ifdef FCALL_ERR_EN
        return (op == 3) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic int ref_winner();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: compare DUT against the model mid-cycle, then advance the model across the edge.
    task automatic cycle();
        int w;
        int exp_rdy;
        rsp_t e;
        #1;
        w = (m_state == 0) ? ref_winner() : -1;
        exp_rdy = (w >= 0) ? (1 << w) : 0;
        chk("req_ready", int'(req_ready), exp_rdy);
        chk("rsp_valid", int'(rsp_valid), m_rv);
        chk("calls_done", int'(calls_done), m_calls);
        if (m_rv != 0) begin
            chk("rsp_id", int'(rsp_id), m_id);
            chk("rsp_data", int'(rsp_data), m_data);
            chk("rsp_err", int'(rsp_err), m_err);
        end
        if (rst) begin
            m_state = 0; m_ptr = 0; m_calls = 0;
            m_rv = 0; m_id = 0; m_data = 0; m_err = 0;
            sb.delete();
        end else begin
            case (m_state)
                0: if (w >= 0) begin
                    lat_id   = w;
                    lat_data = ref_data(int'(req_op[2*w +: 2]), int'(req_x[8*w +: 8]), int'(req_y[8*w +: 8]));
                    lat_err  = ref_err(int'(req_op[2*w +: 2]));
                    sb.push_back('{w, lat_data, lat_err});
                    gnt_log.push_back(w);
                    m_state = 1;
                end
                1: begin
                    m_rv = 1; m_id = lat_id; m_data = lat_data; m_err = lat_err;
                    m_state = 2;
                end
                2: if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_empty", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_id", int'(rsp_id), e.id);
                        chk("sb_data", int'(rsp_data), e.data);
                        chk("sb_err", int'(rsp_err), e.err);
                    end
                    hs_log.push_back(cyc);
                    m_rv = 0;
                    m_ptr = (m_id + 1) % N;
                    m_calls = (m_calls + 1) % 65536;
                    m_state = 0;
                end
                default: m_state = 0;
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && m_state != 0; n++) cycle();
        chk("drain_idle", m_state, 0);
    endtask

    task automatic run_vec(input vec_t v);
        bit done;
        done = 1'b0;
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        req_op[2*v.id +: 2] = 2'(v.op);
        req_x[8*v.id +: 8]  = 8'(v.x);
        req_y[8*v.id +: 8]  = 8'(v.y);
        rsp_ready = 1'b1;
        for (int n = 0; n < 12 && !done; n++) begin
            if (m_state == 2) begin
                chk("vec_id", int'(rsp_id), v.id);
                chk("vec_data", int'(rsp_data), v.exp_data);
                chk("vec_err", int'(rsp_err), v.exp_err);
                done = 1'b1;
            end
            cycle();
            if (m_state == 1) req_valid = '0;
        end
        if (!done) chk("vec_timeout", 0, 1);
        cycle();
    endtask

    vec_t vecs[6];
    int exp_order[5];

    initial begin
        int base_g, base_h, start_calls;
        rst = 1'b1; req_valid = '0; req_op = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_calls_done", int'(calls_done), 0);
        repeat (2) cycle();

        vecs[0] = '{0, 0, 200, 100, 44, 0};
        vecs[1] = '{1, 1, 9, 0, 2, 0};
        vecs[2] = '{2, 2, 55, 77, 1, 0};
`ifdef FCALL_ERR_EN
        vecs[3] = '{3, 3, 3, 4, 0, 1};
`else
        vecs[3] = '{3, 3, 3, 4, 7, 0};
`endif
        vecs[4] = '{1, 0, 255, 1, 0, 0};
        vecs[5] = '{3, 1, 15, 0, 14, 0};
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            chk("vec_calls_done", int'(calls_done), i + 1);
        end

        // All requesters held valid: round-robin order and 3-cycle response spacing.
        exp_order = '{0, 1, 2, 3, 0};
        base_g = gnt_log.size();
        base_h = hs_log.size();
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2] = 2'b00;
            req_x[8*i +: 8]  = 8'(10*i + 7);
            req_y[8*i +: 8]  = 8'(i);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int n = 0; n < 40 && gnt_log.size() < base_g + 5; n++) cycle();
        req_valid = '0;
        drain();
        chk("rr_count", gnt_log.size() - base_g, 5);
        for (int k = 0; k < 5; k++)
            if (base_g + k < gnt_log.size()) chk("rr_order", gnt_log[base_g + k], exp_order[k]);
        for (int k = 1; k < 5; k++)
            if (base_h + k < hs_log.size()) chk("rsp_spacing", hs_log[base_h + k] - hs_log[base_h + k - 1], 3);

        // Back-pressure: response held stable, no grants while stalled.
        req_op[2 +: 2] = 2'b00; req_x[8 +: 8] = 8'd1; req_y[8 +: 8] = 8'd2;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        cycle();
        req_valid = 4'b1100;
        cycle();
        for (int n = 0; n < 5; n++) begin
            chk("stall_valid", int'(rsp_valid), 1);
            chk("stall_data", int'(rsp_data), 3);
            chk("stall_id", int'(rsp_id), 1);
            cycle();
        end
        rsp_ready = 1'b1;
        cycle();
        #1;
        chk("post_stall_gnt", int'(req_ready), 4);
        cycle();
        req_valid = '0;
        drain();

        // Reset during EXEC drops the call and restores reset values.
        start_calls = m_calls;
        req_op[4 +: 2] = 2'b00; req_x[16 +: 8] = 8'd5; req_y[16 +: 8] = 8'd6;
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        chk("rst_in_exec", m_state, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("post_rst_valid", int'(rsp_valid), 0);
        chk("post_rst_id", int'(rsp_id), 0);
        chk("post_rst_data", int'(rsp_data), 0);
        chk("post_rst_err", int'(rsp_err), 0);
        chk("post_rst_calls", int'(calls_done), 0);
        chk("pre_rst_calls_nonzero", (start_calls > 0) ? 1 : 0, 1);
        repeat (3) cycle();
        req_valid = 4'b1111;
        #1;
        chk("post_rst_gnt", int'(req_ready), 1);
        cycle();
        req_valid = '0;
        drain();
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fcall_arbiter.md
# fcall_arbiter

Round-robin arbiter and sequencer that shares one function-evaluation unit (8-bit `sum`, 4-bit `double`, constant `no_args`) among N requesters. Each requester presents an opcode plus arguments with a valid/ready handshake. The block grants one call at a time, evaluates it in a registered execute stage, and returns the result tagged with the requester ID over a valid/ready response port. It sits between the module-level callers and the shared function datapath.

## Interface
- `N_REQ`, 4, number of requesters; power of two, 2..8
- `IDW`, $clog2(N_REQ), requester ID width
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `req_valid` in N_REQ: per-requester call request
- `req_ready` out N_REQ: per-requester accept; one-hot or zero
- `req_op` in 2*N_REQ: opcode per requester, slice [2i+1:2i]
- `req_x` in 8*N_REQ: argument x per requester
- `req_y` in 8*N_REQ: argument y per requester
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: consumer accepts result
- `rsp_id` out IDW: requester that issued the call
- `rsp_data` out 8: result
- `rsp_err` out 1: illegal opcode (only with `FCALL_ERR_EN`)
- `calls_done` out 16: count of completed responses

## Operation
- Opcodes:
  - 00 SUM: x+y, 8-bit, carry discarded.
  - 01 DOUBLE: {4'b0, (x[3:0]*2)[3:0]}, so x=9 gives 2.
  - 10 NO_ARGS: 8'd1; x and y ignored.
  - 11: see Configuration.
- FSM states:
  - IDLE: if any `req_valid`, pick the winner by searching upward from `rr_ptr` with wrap. Assert `req_ready[winner]` combinationally in the same cycle. Latch id/op/x/y and go to EXEC. With no request, stay in IDLE and keep `req_ready`=0.
  - EXEC: compute the result into `rsp_data`/`rsp_err`/`rsp_id` registers, then go to RESP.
  - RESP: hold `rsp_valid`=1 with stable data until `rsp_ready`. On the handshake: `rr_ptr`←winner+1 (mod N_REQ), `calls_done`++ (wraps at 16'hFFFF→0), go to IDLE.
- `req_ready` is 0 in EXEC and RESP. Requests raised there wait.
- A requester may drop `req_valid` before it is granted. Nothing is recorded for it.
- Fairness: a requester that holds `req_valid` is served within N_REQ grants.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `calls_done`=0.
- Accept at edge N (valid&ready in IDLE). `rsp_valid` rises in cycle N+2.
- A response handshake at edge M makes IDLE valid in cycle M+1. The next accept can occur at edge M+1.
- Minimum call period is 3 cycles.
- Back-pressure: `rsp_ready`=0 holds RESP indefinitely, with all response outputs stable.
- Reset asserted in any state wins at the next edge. The in-flight call is dropped: no response, no count, `rr_ptr`=0.
- Simultaneous requests are resolved by `rr_ptr` only. With `rr_ptr`=2 and req 0 and 3 active, 3 wins.

## Configuration
- `FCALL_ERR_EN` defined:
  - Opcode 11 completes normally through EXEC/RESP with `rsp_data`=0 and `rsp_err`=1.
  - Legal ops give `rsp_err`=0.
  - The call still counts in `calls_done`.
- `FCALL_ERR_EN` undefined:
  - Opcode 11 decodes as SUM.
  - `rsp_err` is tied to 0.
  - The error register is not built.

## Test plan
- Reset, then req0 SUM x=200 y=100 → `req_ready`=4'b0001 in the same cycle. `rsp_valid` at +2 with id=0, data=44, err=0. `calls_done`=1 after the handshake.
- req1 DOUBLE x=9 → data=2. req2 NO_ARGS x=55 y=77 → data=1.
- All 4 requesters held valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0. Response edges every 3 cycles.
- `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, data and id stable. No `req_ready` while stalled. Release → next grant in the following cycle.
- `rst` pulsed during EXEC of a SUM from req2 → no response. All outputs return to reset values. The next grant with all requests active goes to req0.
- Opcode 11 x=3 y=4:
  - With `FCALL_ERR_EN`: data=0, err=1.
  - Without `FCALL_ERR_EN`: data=7, err=0.
